sme_host: RTL
=============

SME_HOST -- requirements
Module: sme_host

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port load_data, input, 8 bits: byte to append to a buffer.
REQ-004 SHALL have port load_str_we, input, 1 bit: append load_data to the string buffer.
REQ-005 SHALL have port load_pat_we, input, 1 bit: append load_data to the pattern buffer.
REQ-006 SHALL have port clear, input, 1 bit: empty both buffers.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to run one match job.
REQ-008 SHALL have port keep_str, input, 1 bit: sampled with start; 1 = send pattern only and reuse the string already in the SME.
REQ-009 SHALL have port chardata, output, 8 bits: byte driven to the SME.
REQ-010 SHALL have ports isstring and ispattern, outputs, 1 bit each: SME byte qualifiers.
REQ-011 SHALL have ports valid, match (inputs, 1 bit each) and match_index (input, 5 bits): SME result.
REQ-012 SHALL have port busy, output, 1 bit: job in progress.
REQ-013 SHALL have ports res_valid, res_match, res_err, res_timeout (outputs, 1 bit each) and res_index (output, 5 bits): job result.

Function
REQ-014 SHALL hold a 32-byte string buffer with a 6-bit length (0..32) and an 8-byte pattern buffer with a 4-bit length (0..8).
REQ-015 SHALL, on a write strobe while not busy, store the byte at index = current length and increment that length; a write to a full buffer SHALL be dropped.
REQ-016 SHALL give load_str_we priority over load_pat_we when both are asserted; clear SHALL take priority over both and zero both lengths.
REQ-017 SHALL ignore all writes, clear and start while busy=1.
REQ-018 SHALL implement the FSM IDLE, SEND_STR, SEND_PAT, WAIT, DONE.
REQ-019 In IDLE, start with a legal job SHALL go to SEND_STR, or to SEND_PAT when keep_str=1; busy SHALL assert on the next cycle.
REQ-020 A job SHALL be illegal when pat_len=0, or keep_str=0 with str_len=0, or keep_str=1 with no string sent since reset; an illegal start SHALL go to DONE with res_err=1.
REQ-021 SEND_STR SHALL drive isstring=1 for exactly str_len consecutive cycles, with chardata = str[0..str_len-1] in order.
REQ-022 SEND_PAT SHALL follow SEND_STR with no gap cycle and drive ispattern=1 for exactly pat_len cycles, with chardata = pat[0..pat_len-1].
REQ-023 isstring and ispattern SHALL never both be 1; outside the send states both SHALL be 0 and chardata SHALL be 0.
REQ-024 WAIT SHALL keep both qualifiers low, count cycles in an 8-bit counter, and on valid=1 capture match and match_index and go to DONE.
REQ-025 If 255 WAIT cycles elapse without valid, the FSM SHALL go to DONE with res_timeout=1, res_match=0 and res_index=0.
REQ-026 DONE SHALL last one cycle, pulse res_valid=1 with the captured result, deassert busy on exit, and return to IDLE.
REQ-027 res_match, res_index, res_err and res_timeout SHALL hold their values until the next res_valid pulse.
REQ-028 A valid pulse arriving outside WAIT SHALL be ignored.
REQ-029 Buffers SHALL be retained after a job, so start may be issued again without reloading.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 Reset SHALL immediately force IDLE, clear both lengths and the string-sent flag, and drive chardata, isstring, ispattern, busy and all res_* outputs to 0.
REQ-032 Reset asserted mid-job SHALL abort the job without a res_valid pulse.

Structure
REQ-033 A shared package sme_pkg SHALL hold STR_MAX=32, PAT_MAX=8, TIMEOUT=255, the FSM state encoding, and the SME special-character codes (^=8'h5E, $=8'h24, .=8'h2E, *=8'h2A).
REQ-034 A single parameterized sub-module sme_byte_buf (depth, byte write, indexed read, length, full) SHALL be instantiated twice, once per buffer.

Verification
REQ-035 Load "ab c" (4 bytes) and "^c" (2 bytes), then start -> isstring high for 4 cycles, then ispattern high for 2 cycles; model valid with match=1 and match_index=3 -> res_valid with res_match=1 and res_index=3.
REQ-036 Write 33 string bytes -> str_len=32 and byte 33 dropped; write 9 pattern bytes -> pat_len=8.
REQ-037 With pat_len=0, start -> res_valid with res_err=1 two cycles later, and no qualifier ever asserted.
REQ-038 After a job, load a new pattern and start with keep_str=1 -> no isstring cycles and ispattern on the first send cycle.
REQ-039 Model never returns valid -> res_timeout=1 exactly 255 WAIT cycles after the last ispattern cycle.
REQ-040 Assert reset during SEND_PAT -> qualifiers and busy go to 0 asynchronously, no res_valid, and buffers are empty.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared constants, state encoding and job-legality helper for the SME host.
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    // WAIT gives up after this many cycles without a result from the SME.
    localparam logic [7:0] TIMEOUT = 8'd255;

    // Special characters understood by the SME pattern language.
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_STR = 3'd1,
        ST_SEND_PAT = 3'd2,
        ST_WAIT     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // A job needs a pattern, plus either a string to send now or one the
    // SME already holds from an earlier job.
    function automatic logic job_legal(input logic [3:0] pat_len,
                                       input logic [5:0] str_len,
                                       input logic       keep_str,
                                       input logic       str_sent);
        logic ok;
        if (pat_len == 4'd0) begin
            ok = 1'b0;
        end else if (keep_str) begin
            ok = str_sent;
        end else begin
            ok = (str_len != 6'd0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/sme_byte_buf.sv
// Append-only byte buffer with indexed read, used for both string and pattern.
module sme_byte_buf #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_we,
    input  logic [7:0]    i_data,
    input  logic [AW-1:0] i_rd_idx,
    output logic [7:0]    o_rd_data,
    output logic [LW-1:0] o_len,
    output logic          o_full
);

    logic [7:0]    r_mem [DEPTH];
    logic [LW-1:0] r_len;
    logic          w_push;

    assign o_full    = (r_len == LW'(DEPTH));
    assign w_push    = i_we & ~o_full & ~i_clear;
    assign o_len     = r_len;
    assign o_rd_data = r_mem[i_rd_idx];

    // Fill level: clear empties, an accepted write grows by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
        end else if (i_clear) begin
            r_len <= '0;
        end else if (w_push) begin
            r_len <= r_len + LW'(1);
        end
    end

    // Storage: bytes land at the current fill level; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_len[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/sme_host.sv
// Host sequencer that streams a string and a pattern into an SME and
// collects its match result, with error and timeout reporting.
module sme_host
    import sme_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] load_data,
    input  logic       load_str_we,
    input  logic       load_pat_we,
    input  logic       clear,
    input  logic       start,
    input  logic       keep_str,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       busy,
    output logic       res_valid,
    output logic       res_match,
    output logic       res_err,
    output logic       res_timeout,
    output logic [4:0] res_index
);

    state_t     r_state;
    state_t     w_next_state;
    logic [4:0] r_idx;
    logic [4:0] w_next_idx;
    logic [7:0] r_cnt;
    logic [7:0] w_next_cnt;
    logic       r_str_sent;

    logic       w_idle;
    logic       w_str_we;
    logic       w_pat_we;
    logic       w_clear;
    logic [5:0] w_str_len;
    logic [3:0] w_pat_len;
    logic [7:0] w_str_rd;
    logic [7:0] w_pat_rd;
    logic       w_str_full;
    logic       w_pat_full;

    // Loading is only possible between jobs; clear beats writes, string beats pattern.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_clear  = w_idle & clear;
    assign w_str_we = w_idle & ~clear & load_str_we & ~w_str_full;
    assign w_pat_we = w_idle & ~clear & ~load_str_we & load_pat_we & ~w_pat_full;

    sme_byte_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_clear),
        .i_we      (w_str_we),
        .i_data    (load_data),
        .i_rd_idx  (w_next_idx),
        .o_rd_data (w_str_rd),
        .o_len     (w_str_len),
        .o_full    (w_str_full)
    );

    sme_byte_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_clear),
        .i_we      (w_pat_we),
        .i_data    (load_data),
        .i_rd_idx  (w_next_idx[2:0]),
        .o_rd_data (w_pat_rd),
        .o_len     (w_pat_len),
        .o_full    (w_pat_full)
    );

    // State, send index and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= 5'd0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next state plus the index of the byte to present in the next cycle.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = 5'd0;
        w_next_cnt   = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if (!start) begin
                    w_next_state = ST_IDLE;
                end else if (!job_legal(w_pat_len, w_str_len, keep_str, r_str_sent)) begin
                    w_next_state = ST_DONE;
                end else if (keep_str) begin
                    w_next_state = ST_SEND_PAT;
                end else begin
                    w_next_state = ST_SEND_STR;
                end
            end
            ST_SEND_STR: begin
                if (({1'b0, r_idx} + 6'd1) < w_str_len) begin
                    w_next_idx = r_idx + 5'd1;
                end else begin
                    w_next_state = ST_SEND_PAT;
                end
            end
            ST_SEND_PAT: begin
                if (({1'b0, r_idx} + 6'd1) < {2'b00, w_pat_len}) begin
                    w_next_idx = r_idx + 5'd1;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (valid) begin
                    w_next_state = ST_DONE;
                end else if (r_cnt == (TIMEOUT - 8'd1)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_cnt = r_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // SME-facing outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chardata  <= 8'd0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            isstring  <= (w_next_state == ST_SEND_STR);
            ispattern <= (w_next_state == ST_SEND_PAT);
            busy      <= (w_next_state != ST_IDLE);
            res_valid <= (w_next_state == ST_DONE);
            if (w_next_state == ST_SEND_STR) begin
                chardata <= w_str_rd;
            end else if (w_next_state == ST_SEND_PAT) begin
                chardata <= w_pat_rd;
            end else begin
                chardata <= 8'd0;
            end
        end
    end

    // Result fields change only on entry to DONE and hold until the next job ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_match   <= 1'b0;
            res_err     <= 1'b0;
            res_timeout <= 1'b0;
            res_index   <= 5'd0;
        end else if (w_next_state == ST_DONE) begin
            case (r_state)
                ST_IDLE: begin
                    res_match   <= 1'b0;
                    res_err     <= 1'b1;
                    res_timeout <= 1'b0;
                    res_index   <= 5'd0;
                end
                ST_WAIT: begin
                    res_err     <= 1'b0;
                    res_match   <= valid & match;
                    res_timeout <= ~valid;
                    res_index   <= valid ? match_index : 5'd0;
                end
                default: begin
                    res_match   <= 1'b0;
                    res_err     <= 1'b1;
                    res_timeout <= 1'b0;
                    res_index   <= 5'd0;
                end
            endcase
        end
    end

    // Remembers that the SME holds a string, enabling keep_str jobs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_str_sent <= 1'b0;
        end else if (w_idle && (w_next_state == ST_SEND_STR)) begin
            r_str_sent <= 1'b1;
        end
    end

endmodule
